// File: rtl/text_arb_pkg.sv
// text_arb_pkg
// Shared types and constants for the TextGraphic write-port arbiter.
//   arb_state_t : transfer sequencer states (IDLE, SETUP, STROBE, HOLD)
//   TXT_COLS/TXT_ROWS/TXT_CELLS : character grid geometry
//   AW_DEF/DW_DEF : default cell address / cell word widths
//   *_LSB/*_MSB : field positions inside a cell word {BL, BG, FG, CHAR}
//   pack_cell() : builds a cell word from its fields
package text_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } arb_state_t;

  localparam int TXT_COLS  = 120;
  localparam int TXT_ROWS  = 61;
  localparam int TXT_CELLS = TXT_COLS * TXT_ROWS;

  localparam int AW_DEF = 13;
  localparam int DW_DEF = 18;

  localparam int BL_MSB   = 17;
  localparam int BL_LSB   = 16;
  localparam int BG_MSB   = 15;
  localparam int BG_LSB   = 12;
  localparam int FG_MSB   = 11;
  localparam int FG_LSB   = 8;
  localparam int CHAR_MSB = 7;
  localparam int CHAR_LSB = 0;

  function automatic logic [DW_DEF-1:0] pack_cell(input logic [1:0] bl,
                                                  input logic [3:0] bg,
                                                  input logic [3:0] fg,
                                                  input logic [7:0] ch);
    logic [DW_DEF-1:0] w;
    w = '0;
    w[BL_MSB:BL_LSB]     = bl;
    w[BG_MSB:BG_LSB]     = bg;
    w[FG_MSB:FG_LSB]     = fg;
    w[CHAR_MSB:CHAR_LSB] = ch;
    return w;
  endfunction

endpackage

// File: rtl/text_write_arbiter_rr_pick.sv
// rr_pick
// Combinational rotating-priority picker. Searches last+1, last+2, ...
// (mod NREQ) and reports the first set bit of valid.
//   valid : request vector
//   last  : index of the most recently served requester
//   grant : one-hot winner (all zero when nothing is valid)
//   idx   : winner index
//   any   : at least one requester is valid
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/text_write_arbiter.sv
// text_write_arbiter
// Shares the TextGraphic character-buffer write port between NREQ writers
// using round-robin arbitration over valid/ready channels. Every in-bounds
// grant is sequenced SETUP -> STROBE (Write=1) -> HOLD, so WAddr/WData are
// stable for a full cycle on both sides of the strobe.
// Ports:
//   clk50, rst_n         : clock, synchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (ready is a one-hot pulse)
//   req_addr/req_data    : packed per-requester address / cell word
//   req_lock             : (TEXT_ARB_LOCK_EN only) keep ownership for the
//                          next transfer, used for atomic strings
//   WAddr/WData/Write    : TextGraphic write port
//   grant_id             : owner of the current / last transfer
//   busy                 : sequencer not idle
//   err_oob              : one-cycle pulse after an out-of-bounds accept
// Build option: define TEXT_ARB_LOCK_EN to add req_lock.
module text_write_arbiter
  import text_arb_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int CELLS = TXT_CELLS
) (
  input  logic                     clk50,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*DW-1:0]       req_data,
`ifdef TEXT_ARB_LOCK_EN
  input  logic [NREQ-1:0]          req_lock,
`endif
  output logic [AW-1:0]            WAddr,
  output logic [DW-1:0]            WData,
  output logic                     Write,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     err_oob
);

  localparam int IW = $clog2(NREQ);

  arb_state_t      state, state_next;
  logic [IW-1:0]   rr_last;
  logic [NREQ-1:0] rr_grant;
  logic [IW-1:0]   rr_idx;
  logic            rr_any;
  logic [NREQ-1:0] win_grant;
  logic [IW-1:0]   win_idx;
  logic            win_any;
  logic            win_locked;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic            win_oob;
  logic            accept;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .valid (req_valid),
    .last  (rr_last),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

`ifdef TEXT_ARB_LOCK_EN
  // Set during the IDLE cycle right after a HOLD whose owner asked to keep
  // the port; that owner then bypasses round-robin once.
  logic lock_hold;

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      lock_hold <= 1'b0;
    end else begin
      lock_hold <= (state == HOLD) && req_lock[grant_id] && req_valid[grant_id];
    end
  end

  always_comb begin
    win_locked = lock_hold && req_valid[grant_id];
    win_grant  = rr_grant;
    win_idx    = rr_idx;
    win_any    = rr_any;
    if (win_locked) begin
      win_grant           = '0;
      win_grant[grant_id] = 1'b1;
      win_idx             = grant_id;
      win_any             = 1'b1;
    end
  end
`else
  always_comb begin
    win_locked = 1'b0;
    win_grant  = rr_grant;
    win_idx    = rr_idx;
    win_any    = rr_any;
  end
`endif

  assign win_addr = req_addr[int'(win_idx)*AW +: AW];
  assign win_data = req_data[int'(win_idx)*DW +: DW];
  assign win_oob  = (int'(win_addr) >= CELLS);
  assign busy     = (state != IDLE);

  // Ready is offered only while idle and out of reset. An out-of-bounds
  // request is still accepted (and flagged) so its writer is not stuck.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rst_n && win_any) begin
          req_ready = win_grant;
          accept    = 1'b1;
          if (!win_oob) state_next = SETUP;
        end
      end
      SETUP:   state_next = STROBE;
      STROBE:  state_next = HOLD;
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write is registered off SETUP so it is high exactly while in STROBE.
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_last  <= IW'(NREQ - 1);
      Write    <= 1'b0;
      WAddr    <= '0;
      WData    <= '0;
      grant_id <= '0;
      err_oob  <= 1'b0;
    end else begin
      state   <= state_next;
      Write   <= (state == SETUP);
      err_oob <= accept && win_oob;
      if (accept) begin
        grant_id <= win_idx;
        if (!win_locked) rr_last <= win_idx;
        if (!win_oob) begin
          WAddr <= win_addr;
          WData <= win_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_text_write_arbiter.sv
// tb_text_write_arbiter
// Randomised self-checking bench. A transaction-level model tracks the
// round-robin pointer and the number of cycles since the last accepted
// write, and predicts ready, the write strobe and the output registers.
module tb_text_write_arbiter;
  import text_arb_pkg::*;

  localparam int NREQ  = 3;
  localparam int AW    = 13;
  localparam int DW    = 18;
  localparam int IW    = 2;
  localparam int CELLS = TXT_CELLS;

  logic                 clk50 = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
`ifdef TEXT_ARB_LOCK_EN
  logic [NREQ-1:0]      req_lock;
`endif
  logic [AW-1:0]        WAddr;
  logic [DW-1:0]        WData;
  logic                 Write;
  logic [IW-1:0]        grant_id;
  logic                 busy;
  logic                 err_oob;

  logic [AW-1:0] a [NREQ];
  logic [DW-1:0] d [NREQ];

  int errors = 0;
  int checks = 0;

  // model state
  int              m_age;
  int              m_rr;
  int              m_gid;
  int              m_win;
  int              acc_id;
  bit              m_locked;
  bit              m_lock_pend;
  logic            m_write;
  logic            m_err;
  logic [AW-1:0]   m_waddr;
  logic [DW-1:0]   m_wdata;
  logic [NREQ-1:0] exp_ready;
  logic [NREQ-1:0] obs_ready;

  always #5 clk50 = ~clk50;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
  end

  text_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CELLS(CELLS)) dut (
    .clk50     (clk50),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
`ifdef TEXT_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .WAddr     (WAddr),
    .WData     (WData),
    .Write     (Write),
    .grant_id  (grant_id),
    .busy      (busy),
    .err_oob   (err_oob)
  );

  function automatic int rr_search(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] rand_cell();
    return pack_cell(2'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));
  endfunction

  task automatic model_reset();
    m_age       = 0;
    m_rr        = NREQ - 1;
    m_gid       = 0;
    m_write     = 1'b0;
    m_err       = 1'b0;
    m_waddr     = '0;
    m_wdata     = '0;
    m_lock_pend = 1'b0;
  endtask

  // Predict ready before the edge, advance the model across the edge, then
  // leave time 1 unit after the edge for the caller to sample outputs.
  // m_age counts cycles since an accepted write; 0 means the port is free.
  task automatic cycle();
    bit lock_next;
    @(negedge clk50);
    m_win    = -1;
    m_locked = 1'b0;
    if (rst_n && m_age == 0) begin
      m_win = rr_search(req_valid, m_rr);
`ifdef TEXT_ARB_LOCK_EN
      m_locked = m_lock_pend && req_valid[m_gid];
      if (m_locked) m_win = m_gid;
`endif
    end
    exp_ready = (m_win >= 0) ? (NREQ'(1) << m_win) : '0;
    obs_ready = req_ready;
    @(posedge clk50);
    acc_id    = -1;
    lock_next = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_err = 1'b0;
      if (m_age == 0) begin
        if (m_win >= 0) begin
          acc_id = m_win;
          m_gid  = m_win;
          if (!m_locked) m_rr = m_win;
          if (int'(a[m_win]) >= CELLS) begin
            m_err = 1'b1;
          end else begin
            m_waddr = a[m_win];
            m_wdata = d[m_win];
            m_age   = 1;
          end
        end
      end else begin
`ifdef TEXT_ARB_LOCK_EN
        if (m_age == 3) lock_next = req_lock[m_gid] && req_valid[m_gid];
`endif
        m_age = (m_age + 1) % 4;
      end
      m_lock_pend = lock_next;
      m_write     = (m_age == 2);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
`ifdef TEXT_ARB_LOCK_EN
    req_lock  = '0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    model_reset();
    repeat (2) cycle();
    if (Write !== 1'b0)    begin errors++; $display("[TB] FAIL reset.Write got=%0b want=0", Write); end
    checks++;
    if (WAddr !== '0)      begin errors++; $display("[TB] FAIL reset.WAddr got=%0h want=0", WAddr); end
    checks++;
    if (WData !== '0)      begin errors++; $display("[TB] FAIL reset.WData got=%0h want=0", WData); end
    checks++;
    if (grant_id !== '0)   begin errors++; $display("[TB] FAIL reset.grant_id got=%0d want=0", grant_id); end
    checks++;
    if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL reset.busy got=%0b want=0", busy); end
    checks++;
    if (err_oob !== 1'b0)  begin errors++; $display("[TB] FAIL reset.err_oob got=%0b want=0", err_oob); end
    checks++;
    if (obs_ready !== '0)  begin errors++; $display("[TB] FAIL reset.ready got=%b want=000", obs_ready); end
    checks++;
  endtask

  task automatic test_single_write();
    int readies = 0;
    int writes  = 0;
    int acc_cyc = -1;
    int wr_cyc  = -1;
    rst_n     = 1'b1;
    a[0]      = 13'h0005;
    d[0]      = 18'h0A541;
    req_valid = 3'b001;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (obs_ready !== exp_ready) begin errors++; $display("[TB] FAIL single.ready c=%0d got=%b want=%b", c, obs_ready, exp_ready); end
      checks++;
      if (Write !== m_write) begin errors++; $display("[TB] FAIL single.Write c=%0d got=%0b want=%0b", c, Write, m_write); end
      checks++;
      if (Write === 1'b1) begin
        writes++;
        wr_cyc = c + 1;
        if (WAddr !== 13'h0005 || WData !== 18'h0A541) begin
          errors++;
          $display("[TB] FAIL single.port got=%0h/%0h want=5/a541", WAddr, WData);
        end
        checks++;
      end
      if (obs_ready[0]) begin
        readies++;
        acc_cyc   = c;
        req_valid = '0;
      end
    end
    if (readies !== 1) begin errors++; $display("[TB] FAIL single.ready_count got=%0d want=1", readies); end
    checks++;
    if (writes !== 1) begin errors++; $display("[TB] FAIL single.write_count got=%0d want=1", writes); end
    checks++;
    if (wr_cyc - acc_cyc !== 2) begin errors++; $display("[TB] FAIL single.latency got=%0d want=2", wr_cyc - acc_cyc); end
    checks++;
  endtask

  task automatic test_round_robin();
    int seq[$];
    int writes = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (2) cycle();
    rst_n = 1'b1;
    a[0] = 13'd10; a[1] = 13'd20; a[2] = 13'd30;
    for (int i = 0; i < NREQ; i++) d[i] = rand_cell();
    req_valid = 3'b111;
    for (int c = 0; c < 16; c++) begin
      cycle();
      if (obs_ready !== exp_ready) begin errors++; $display("[TB] FAIL rr.ready c=%0d got=%b want=%b", c, obs_ready, exp_ready); end
      checks++;
      if (Write !== m_write) begin errors++; $display("[TB] FAIL rr.Write c=%0d got=%0b want=%0b", c, Write, m_write); end
      checks++;
      if (Write === 1'b1) begin
        writes++;
        if (WAddr !== m_waddr || WData !== m_wdata || grant_id !== IW'(m_gid)) begin
          errors++;
          $display("[TB] FAIL rr.owner got=%0d/%0h/%0h want=%0d/%0h/%0h", grant_id, WAddr, WData, m_gid, m_waddr, m_wdata);
        end
        checks++;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (obs_ready[i]) begin
          seq.push_back(i);
          d[i] = rand_cell();
        end
      end
    end
    req_valid = '0;
    if (writes !== 4) begin errors++; $display("[TB] FAIL rr.write_count got=%0d want=4", writes); end
    checks++;
    if (seq.size() < 4 || seq[0] != 0 || seq[1] != 1 || seq[2] != 2 || seq[3] != 0) begin
      errors++;
      $display("[TB] FAIL rr.sequence got=%p want=0,1,2,0", seq);
    end
    checks++;
  endtask

  task automatic test_oob();
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    int errs   = 0;
    int writes = 0;
    prev_addr = m_waddr;
    prev_data = m_wdata;
    a[1]      = 13'd7320;
    d[1]      = rand_cell();
    req_valid = 3'b010;
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (obs_ready !== exp_ready) begin errors++; $display("[TB] FAIL oob.ready c=%0d got=%b want=%b", c, obs_ready, exp_ready); end
      checks++;
      if (err_oob !== m_err) begin errors++; $display("[TB] FAIL oob.err c=%0d got=%0b want=%0b", c, err_oob, m_err); end
      checks++;
      if (err_oob === 1'b1) errs++;
      if (Write === 1'b1) writes++;
      if (WAddr !== prev_addr || WData !== prev_data) begin
        errors++;
        $display("[TB] FAIL oob.port_changed got=%0h/%0h want=%0h/%0h", WAddr, WData, prev_addr, prev_data);
      end
      checks++;
      if (obs_ready[1]) req_valid = '0;
    end
    if (errs !== 1) begin errors++; $display("[TB] FAIL oob.err_count got=%0d want=1", errs); end
    checks++;
    if (writes !== 0) begin errors++; $display("[TB] FAIL oob.write_count got=%0d want=0", writes); end
    checks++;
    a[1]      = 13'd7319;
    d[1]      = rand_cell();
    req_valid = 3'b010;
    writes    = 0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (obs_ready[1]) req_valid = '0;
      if (err_oob !== 1'b0) begin errors++; $display("[TB] FAIL edge.err c=%0d got=%0b want=0", c, err_oob); end
      checks++;
      if (Write === 1'b1) begin
        writes++;
        if (WAddr !== 13'd7319 || WData !== d[1]) begin
          errors++;
          $display("[TB] FAIL edge.port got=%0h/%0h want=1c97/%0h", WAddr, WData, d[1]);
        end
        checks++;
      end
    end
    if (writes !== 1) begin errors++; $display("[TB] FAIL edge.write_count got=%0d want=1", writes); end
    checks++;
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    a[0]      = 13'($urandom_range(CELLS - 1));
    d[0]      = rand_cell();
    req_valid = 3'b001;
    while (!m_write && guard < 10) begin
      cycle();
      guard++;
      if (obs_ready[0]) req_valid = '0;
    end
    if (Write !== 1'b1) begin errors++; $display("[TB] FAIL midrst.strobe got=%0b want=1", Write); end
    checks++;
    rst_n     = 1'b0;
    req_valid = 3'b111;
    cycle();
    if (Write !== 1'b0 || busy !== 1'b0 || err_oob !== 1'b0 || WAddr !== '0 || WData !== '0 || grant_id !== '0) begin
      errors++;
      $display("[TB] FAIL midrst.outputs got=W%0b b%0b e%0b %0h/%0h g%0d want=all zero",
               Write, busy, err_oob, WAddr, WData, grant_id);
    end
    checks++;
    if (obs_ready !== '0) begin errors++; $display("[TB] FAIL midrst.ready_in_reset got=%b want=000", obs_ready); end
    checks++;
    rst_n = 1'b1;
    cycle();
    if (obs_ready !== 3'b001) begin errors++; $display("[TB] FAIL midrst.first_grant got=%b want=001", obs_ready); end
    checks++;
    req_valid = '0;
    repeat (4) cycle();
  endtask

  task automatic test_starvation();
    int others = 0;
    bit got2   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 13'($urandom_range(CELLS - 1));
      d[i] = rand_cell();
    end
    req_valid = 3'b100;
    for (int c = 0; c < 60 && !got2; c++) begin
      req_valid[0] = 1'($urandom);
      req_valid[1] = 1'($urandom);
      cycle();
      if (obs_ready !== exp_ready) begin errors++; $display("[TB] FAIL starve.ready c=%0d got=%b want=%b", c, obs_ready, exp_ready); end
      checks++;
      if (Write !== m_write) begin errors++; $display("[TB] FAIL starve.Write c=%0d got=%0b want=%0b", c, Write, m_write); end
      checks++;
      if (obs_ready[2]) got2 = 1'b1;
      else if (obs_ready !== '0) others++;
      for (int i = 0; i < NREQ; i++) if (obs_ready[i]) d[i] = rand_cell();
    end
    req_valid = '0;
    if (!got2) begin errors++; $display("[TB] FAIL starve.timeout got=no grant want=grant to 2"); end
    checks++;
    if (others > NREQ - 1) begin errors++; $display("[TB] FAIL starve.bypassed got=%0d want<=%0d", others, NREQ - 1); end
    checks++;
    repeat (4) cycle();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] pend;
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          a[i] = ($urandom_range(7) == 0) ? 13'($urandom_range(8191, CELLS))
                                           : 13'($urandom_range(CELLS - 1));
          d[i] = rand_cell();
        end
      end
      req_valid = pend;
      rst_n     = ($urandom_range(63) != 0);
      cycle();
      if (obs_ready !== exp_ready) begin errors++; $display("[TB] FAIL rand.ready c=%0d got=%b want=%b", c, obs_ready, exp_ready); end
      checks++;
      if (Write !== m_write || busy !== (m_age != 0) || err_oob !== m_err) begin
        errors++;
        $display("[TB] FAIL rand.ctrl c=%0d got=W%0b b%0b e%0b want=W%0b b%0b e%0b",
                 c, Write, busy, err_oob, m_write, (m_age != 0), m_err);
      end
      checks++;
      if (WAddr !== m_waddr || WData !== m_wdata || grant_id !== IW'(m_gid)) begin
        errors++;
        $display("[TB] FAIL rand.regs c=%0d got=%0h/%0h/%0d want=%0h/%0h/%0d",
                 c, WAddr, WData, grant_id, m_waddr, m_wdata, m_gid);
      end
      checks++;
      pend = pend & ~obs_ready;
    end
    rst_n     = 1'b1;
    req_valid = '0;
    repeat (4) cycle();
  endtask

`ifdef TEXT_ARB_LOCK_EN
  task automatic test_lock();
    int seq[$];
    int ones = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    repeat (2) cycle();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 13'($urandom_range(CELLS - 1));
      d[i] = rand_cell();
    end
    req_lock  = 3'b010;
    req_valid = 3'b010;
    for (int c = 0; c < 30 && seq.size() < 5; c++) begin
      cycle();
      if (obs_ready !== exp_ready) begin errors++; $display("[TB] FAIL lock.ready c=%0d got=%b want=%b", c, obs_ready, exp_ready); end
      checks++;
      for (int i = 0; i < NREQ; i++) begin
        if (obs_ready[i]) begin
          seq.push_back(i);
          d[i] = rand_cell();
          if (i == 1) ones++;
        end
      end
      if (ones == 3) begin
        req_lock     = '0;
        req_valid[1] = 1'b0;
      end
      if (ones >= 1 && ones < 3) req_valid = 3'b111;
      if (ones == 3) req_valid = req_valid & 3'b101;
      if (ones >= 3 && seq.size() >= 4) req_valid[2] = 1'b0;
    end
    req_valid = '0;
    if (seq.size() != 5 || seq[0] != 1 || seq[1] != 1 || seq[2] != 1 || seq[3] != 2 || seq[4] != 0) begin
      errors++;
      $display("[TB] FAIL lock.sequence got=%p want=1,1,1,2,0", seq);
    end
    checks++;
    repeat (4) cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_oob();
    test_reset_mid();
    test_starvation();
    test_random();
`ifdef TEXT_ARB_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/text_write_arbiter.md
Name: text_write_arbiter

Overview:
Shares the single TextGraphic character-buffer write port (WAddr/WData/Write) between several independent writers, e.g. screen filler, console printer and status overlay. Round-robin arbitration over valid/ready request channels. Each granted request is sequenced as address/data setup, then a one-cycle Write strobe, then hold. Sits between the writers and TextGraphic, clocked on the same clk50 domain as the write clock.

Parameters:
NREQ, 3, number of requesters (2..8)
AW, 13, cell address width
DW, 18, cell word width {BL[17:16], BG[15:12], FG[11:8], Char[7:0]}
CELLS, 7320, valid cell count (120 cols x 61 rows); addresses >= CELLS are out of bounds

Ports:
clk50  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  NREQ  request pending per requester
req_ready  out  NREQ  one-hot accept pulse
req_addr  in  NREQ*AW  packed cell addresses, requester i at [i*AW +: AW]
req_data  in  NREQ*DW  packed cell words, requester i at [i*DW +: DW]
WAddr  out  AW  to TextGraphic
WData  out  DW  to TextGraphic
Write  out  1  write strobe to TextGraphic
grant_id  out  clog2(NREQ)  requester owning the current/last transfer
busy  out  1  high in any state other than IDLE
err_oob  out  1  one-cycle pulse on an out-of-bounds request

Behaviour:
- Reset values (rst_n low at an edge): Write=0, WAddr=0, WData=0, grant_id=0, busy=0, err_oob=0, req_ready=0, state=IDLE, rr_last=NREQ-1, so requester 0 wins first.
- Handshake: transfer occurs when req_valid[i] & req_ready[i]. Requester holds valid, addr and data stable until ready. req_ready is asserted only in IDLE, only for the winner, and is combinational from state and valid.
- Arbitration: the winner is the first i with valid[i], searching rr_last+1, rr_last+2, ... mod NREQ. On accept, rr_last=i.
- State machine:
  - IDLE: no valid -> stay. Winner in bounds -> capture WAddr/WData/grant_id, go SETUP. Winner out of bounds (addr >= CELLS) -> accept, err_oob=1 next cycle, grant_id updated, WAddr/WData unchanged, stay IDLE.
  - SETUP: Write=0, outputs stable -> STROBE.
  - STROBE: Write=1 for exactly one cycle -> HOLD.
  - HOLD: Write=0, WAddr/WData still held -> IDLE.
- Timing: Write is registered. Accept at edge N gives Write high during cycle N+2. Max throughput is one write per 4 cycles.
- WAddr/WData change only on an in-bounds accept. They never change while Write=1, nor in the cycle before or after it.
- Simultaneous requests: all NREQ valid continuously -> grants rotate 0,1,2,0,...
- A requester dropping valid before ready is a protocol violation, not checked. Its request is simply not granted.
- Reset mid-transfer: Write returns to 0 at that edge and the transfer is abandoned. No second ready is issued for it.

Optional Feature:
TEXT_ARB_LOCK_EN: adds input req_lock[NREQ].
- With it: if in HOLD the granted requester has req_lock and req_valid high, it wins the next IDLE regardless of round-robin, and rr_last is not advanced. This allows atomic multi-cell strings.
- Without it: port absent, pure round-robin.

Decomposition:
- Package text_arb_pkg:
  - state enum {IDLE, SETUP, STROBE, HOLD}
  - TXT_COLS=120, TXT_ROWS=61, CELLS
  - AW/DW defaults
  - WData field positions (BL, BG, FG, CHAR)
- One sub-module, rr_pick: combinational rotate-priority picker (valid vector, last index -> one-hot grant + index).

Test Plan:
1. Reset release, then req_valid=001, addr=0x0005, data=0x0A541: ready[0] pulses once. Write high exactly one cycle, 2 cycles after accept, with WAddr=0x0005, WData=0x0A541.
2. All three valid continuously, distinct addrs 10/20/30: Write strobes every 4 cycles, grant_id sequence 0,1,2,0; WAddr matches each owner.
3. req_valid=010, addr=7320: ready[1] pulses, err_oob pulses once, Write stays 0, WAddr/WData unchanged. Then addr=7319 is written normally.
4. Assert rst_n=0 in the STROBE cycle: Write=0 next cycle, all outputs at reset values, busy=0. The next grant goes to requester 0.
5. Requester 2 holds valid while 0 and 1 toggle: requester 2 is granted within NREQ arbitration rounds (no starvation).
6. TEXT_ARB_LOCK_EN defined, req_lock[1]=1 for 3 writes with 0 and 2 valid: grant_id=1,1,1, then 2, then 0.
